// File: rtl/piradip_ram_port_arbiter.sv
// piradip_ram_port_arbiter
// Shares one single-port RAM between NUM_REQ beat-level requesters.
// Round-robin arbitration with the grant held for a whole burst (until the
// beat flagged req_last). Read data is returned on a shared bus, tagged
// one-hot per requester, READ_LATENCY cycles after the read beat is accepted.
//
// Optional feature macro: PIRADIP_RAM_ARB_TIMEOUT_EN
//   defined   : a burst whose owner keeps req_valid low for TIMEOUT_CYCLES
//               grant cycles is forcibly released, with a one-cycle
//               arb_timeout pulse.
//   undefined : arb_timeout is tied low and a grant is held until req_last.
//
// Handshake: a beat on requester i transfers in a cycle where
// req_valid[i] & req_ready[i] are both high. A requester holds its beat
// (valid, we, last, addr, wdata, be) stable until it transfers; req_ready
// only ever rises for the current owner while in GRANT. Read responses have
// no backpressure and must be consumed in the cycle rsp_valid is high.
module piradip_ram_port_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int WE_WIDTH       = 1,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*WE_WIDTH-1:0]    req_be,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           mem_en,
    output logic [WE_WIDTH-1:0]            mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           arb_timeout,
    output logic                           dbg_state
);

    localparam int OW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || READ_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("piradip_ram_port_arbiter: illegal parameter value");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OW-1:0]           r_owner;
    logic [OW-1:0]           w_owner_nxt;
    logic [OW-1:0]           r_rr_ptr;
    logic [OW-1:0]           w_rr_ptr_nxt;

    logic                    w_sel_valid;
    logic                    w_sel_we;
    logic                    w_sel_last;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic [WE_WIDTH-1:0]     w_sel_be;

    logic                    w_accept;
    logic                    w_timeout;
    logic                    w_release;
    logic [OW:0]             w_pick_idle;
    logic [OW:0]             w_pick_next;

    logic [READ_LATENCY-1:0] r_pipe_v;
    logic [OW-1:0]           r_pipe_id [READ_LATENCY];

    // First requester with valid set, scanning upward from start with wrap.
    // When skip_en is set, requester 'skip' is excluded. Result is
    // {found, index}.
    function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input int start,
                                            input logic skip_en,
                                            input int skip);
        logic [OW:0] res;
        int          idx;
        res = '0;
        // Scan from the far end so the nearest eligible requester wins last.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (start + off) % NUM_REQ;
            if (v[idx] && !(skip_en && idx == skip)) begin
                res = {1'b1, idx[OW-1:0]};
            end
        end
        return res;
    endfunction

    // Mux the owner's slice out of the flattened request buses.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_we    = req_we[i];
                w_sel_last  = req_last[i];
                w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be    = req_be[i*WE_WIDTH +: WE_WIDTH];
            end
        end
    end

    assign w_accept    = (r_state == ST_GRANT) && w_sel_valid;
    assign w_release   = (w_accept && w_sel_last) || w_timeout;
    assign w_pick_idle = rr_pick(req_valid, int'(r_rr_ptr), 1'b0, 0);
    assign w_pick_next = rr_pick(req_valid, int'(r_owner) + 1, 1'b1, int'(r_owner));

`ifdef PIRADIP_RAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_stall_cnt;
    logic          w_stall;

    assign w_stall   = (r_state == ST_GRANT) && !w_sel_valid;
    // Fire on the stall cycle that would bring the count to TIMEOUT_CYCLES.
    assign w_timeout = w_stall && (r_stall_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Stall counter: cleared outside GRANT, on every accepted beat and on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state != ST_GRANT || w_accept || w_release) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Next-state: arbitrate from IDLE, or hand over directly at burst end.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[OW]) begin
                    w_owner_nxt = w_pick_idle[OW-1:0];
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_rr_ptr_nxt = OW'((int'(r_owner) + 1) % NUM_REQ);
                    if (w_pick_next[OW]) begin
                        w_owner_nxt = w_pick_next[OW-1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Only the owner sees ready, and only while granted.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_GRANT) begin
            req_ready[r_owner] = 1'b1;
        end
    end

    assign mem_en    = w_accept;
    assign mem_we    = (w_accept && w_sel_we) ? w_sel_be : '0;
    assign mem_addr  = (r_state == ST_GRANT) ? w_sel_addr : '0;
    assign mem_wdata = (r_state == ST_GRANT) ? w_sel_wdata : '0;

    // Read-return pipe: one {valid, owner} entry per cycle, READ_LATENCY deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_v <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_pipe_v[0]  <= w_accept && !w_sel_we;
            r_pipe_id[0] <= r_owner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
        end
    end

    // Decode the pipe tail into a one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        if (r_pipe_v[READ_LATENCY-1]) begin
            rsp_valid[r_pipe_id[READ_LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_rdata   = (|rsp_valid) ? mem_rdata : '0;
    assign arb_timeout = w_timeout;
    assign dbg_state   = r_state;

endmodule
